// File: rtl/spectrum_power_stream_pkg.sv
// Shared types and helpers for the spectrum power stream front end.
package spectrum_power_stream_pkg;

  // Framing state of the input frame tracker.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SKIP = 2'd2
  } frame_state_e;

  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 24;
  localparam int SKIP_W    = 4;
  localparam int CNT_W     = 16;

  // Shift a nonnegative sum right and clamp it to the largest out_w-bit value.
  function automatic logic [63:0] sat_shift(input logic [63:0] value,
                                            input int          shift,
                                            input int          out_w);
    logic [63:0] shifted;
    logic [63:0] max_val;
    shifted = value >> shift;
    max_val = (64'd1 << out_w) - 64'd1;
    if (shifted > max_val) begin
      return max_val;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/spectrum_power_stream_power_sq_pipe.sv
// Three-stage |X|^2 pipeline: register inputs, square both parts, then sum,
// shift and saturate. Frame side-band bits ride along at the same depth.
module power_sq_pipe
  import spectrum_power_stream_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   in_err,
  input  logic signed [IN_W-1:0] in_real,
  input  logic signed [IN_W-1:0] in_imag,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_err,
  output logic [OUT_W-1:0]       out_data
);

  localparam int PW = 2 * IN_W;

  logic                   s1_valid_d, s1_valid_q;
  logic                   s1_sop_d, s1_sop_q;
  logic                   s1_eop_d, s1_eop_q;
  logic                   s1_err_d, s1_err_q;
  logic signed [IN_W-1:0] s1_re_d, s1_re_q;
  logic signed [IN_W-1:0] s1_im_d, s1_im_q;

  logic                   s2_valid_d, s2_valid_q;
  logic                   s2_sop_d, s2_sop_q;
  logic                   s2_eop_d, s2_eop_q;
  logic                   s2_err_d, s2_err_q;
  logic [PW-1:0]          s2_re_sq_d, s2_re_sq_q;
  logic [PW-1:0]          s2_im_sq_d, s2_im_sq_q;

  logic                   out_valid_d, out_valid_q;
  logic                   out_sop_d, out_sop_q;
  logic                   out_eop_d, out_eop_q;
  logic                   out_err_d, out_err_q;
  logic [OUT_W-1:0]       out_data_d, out_data_q;

  logic signed [PW-1:0]   re_ext_s;
  logic signed [PW-1:0]   im_ext_s;
  logic [PW:0]            sum_s;

  // Stage 1: capture the beat; markers are qualified by valid here.
  always_comb begin
    s1_valid_d = in_valid;
    s1_sop_d   = in_valid & in_sop;
    s1_eop_d   = in_valid & in_eop;
    s1_err_d   = in_err;
    s1_re_d    = in_real;
    s1_im_d    = in_imag;
  end

  // Stage 2: square each part at full product width; squares are never negative.
  always_comb begin
    re_ext_s   = {{IN_W{s1_re_q[IN_W-1]}}, s1_re_q};
    im_ext_s   = {{IN_W{s1_im_q[IN_W-1]}}, s1_im_q};
    s2_re_sq_d = re_ext_s * re_ext_s;
    s2_im_sq_d = im_ext_s * im_ext_s;
    s2_valid_d = s1_valid_q;
    s2_sop_d   = s1_sop_q;
    s2_eop_d   = s1_eop_q;
    s2_err_d   = s1_err_q;
  end

  // Stage 3: one extra bit for the sum, then shift/saturate; data is zero when idle.
  always_comb begin
    sum_s       = {1'b0, s2_re_sq_q} + {1'b0, s2_im_sq_q};
    out_valid_d = s2_valid_q;
    out_sop_d   = s2_valid_q & s2_sop_q;
    out_eop_d   = s2_valid_q & s2_eop_q;
    out_err_d   = s2_err_q;
    out_data_d  = s2_valid_q ? OUT_W'(sat_shift(64'(sum_s), SHIFT, OUT_W))
                             : {OUT_W{1'b0}};
  end

  // Pipeline registers; reset clears every stage so no stale beat escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_re_q     <= {IN_W{1'b0}};
      s1_im_q     <= {IN_W{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_sop_q    <= 1'b0;
      s2_eop_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_re_sq_q  <= {PW{1'b0}};
      s2_im_sq_q  <= {PW{1'b0}};
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      s1_err_q    <= s1_err_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s2_valid_q  <= s2_valid_d;
      s2_sop_q    <= s2_sop_d;
      s2_eop_q    <= s2_eop_d;
      s2_err_q    <= s2_err_d;
      s2_re_sq_q  <= s2_re_sq_d;
      s2_im_sq_q  <= s2_im_sq_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/spectrum_power_stream.sv
// Power-spectrum stream front end: frame tracking, decimation and frame
// length enforcement around the |X|^2 pipeline.
module spectrum_power_stream
  import spectrum_power_stream_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int FRAME_LEN = 64,
  parameter int SHIFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic signed [IN_W-1:0] in_real,
  input  logic signed [IN_W-1:0] in_imag,
  input  logic [SKIP_W-1:0]      frame_skip,
  output logic                   source_valid,
  output logic                   source_sop,
  output logic                   source_eop,
  output logic [OUT_W-1:0]       source_data,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int               BIN_W    = $clog2(FRAME_LEN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  frame_state_e      state_d, state_q;
  logic [BIN_W-1:0]  bin_d, bin_q;
  logic [SKIP_W-1:0] skip_d, skip_q;
  logic [CNT_W-1:0]  frame_cnt_d, frame_cnt_q;

  frame_state_e      open_state_s;
  logic              last_bin_s;
  logic              fwd_valid_s;
  logic              fwd_sop_s;
  logic              fwd_eop_s;
  logic              fwd_err_s;

  // Frame tracker: decides per beat whether it is forwarded and which markers it carries.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    skip_d       = skip_q;
    open_state_s = ST_RUN;
    fwd_valid_s  = 1'b0;
    fwd_sop_s    = 1'b0;
    fwd_eop_s    = 1'b0;
    fwd_err_s    = 1'b0;
    last_bin_s   = (bin_q == LAST_BIN);
    if (in_valid && in_sop) begin
      // A frame start always begins at bin 0; an open frame is abandoned and a
      // sop+eop beat is a one-bin frame, both of which are framing errors.
      fwd_err_s = (state_q != ST_IDLE) || in_eop;
      if (skip_q == {SKIP_W{1'b0}}) begin
        skip_d       = frame_skip;
        open_state_s = ST_RUN;
        fwd_valid_s  = 1'b1;
        fwd_sop_s    = 1'b1;
        fwd_eop_s    = in_eop;
      end else begin
        skip_d       = skip_q - {{(SKIP_W-1){1'b0}}, 1'b1};
        open_state_s = ST_SKIP;
      end
      if (in_eop) begin
        state_d = ST_IDLE;
        bin_d   = {BIN_W{1'b0}};
      end else begin
        state_d = open_state_s;
        bin_d   = {{(BIN_W-1){1'b0}}, 1'b1};
      end
    end else if (in_valid) begin
      case (state_q)
        ST_RUN, ST_SKIP: begin
          fwd_valid_s = (state_q == ST_RUN);
          fwd_eop_s   = (state_q == ST_RUN) && (in_eop || last_bin_s);
          // Early eop and a missing eop on the last bin are both violations.
          fwd_err_s   = in_eop ^ last_bin_s;
          if (in_eop || last_bin_s) begin
            state_d = ST_IDLE;
            bin_d   = {BIN_W{1'b0}};
          end else begin
            bin_d = bin_q + {{(BIN_W-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          bin_d   = {BIN_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Forwarded-frame counter advances once per emitted end-of-frame beat.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, (source_valid & source_eop)};
  end

  // Tracker and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bin_q       <= {BIN_W{1'b0}};
      skip_q      <= {SKIP_W{1'b0}};
      frame_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      skip_q      <= skip_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  power_sq_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_power_sq_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fwd_valid_s),
    .in_sop   (fwd_sop_s),
    .in_eop   (fwd_eop_s),
    .in_err   (fwd_err_s),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(source_valid),
    .out_sop  (source_sop),
    .out_eop  (source_eop),
    .out_err  (frame_err),
    .out_data (source_data)
  );

  assign frame_cnt = frame_cnt_q;

endmodule
